clk_en_gen: RTL and testbench



---
 rtl/clk_en_gen.sv | 115 +++++++++++
 tb/tb_clk_en_gen.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator: per-channel strobe every (div+1) cycles plus a
// toggle output, with deferred divisor update, global phase sync and a startup lock delay.
module clk_en_gen #(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int RESET_DIV   = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [CHANNELS*WIDTH-1:0] div_i,
  input  logic [CHANNELS-1:0]       div_we_i,
  input  logic [CHANNELS-1:0]       chan_en_i,
  input  logic                      sync_i,
  output logic [CHANNELS-1:0]       stb_o,
  output logic [CHANNELS-1:0]       tgl_o,
  output logic [CHANNELS-1:0]       pend_o,
  output logic                      ready_o
);

  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [WIDTH-1:0] RDIV = WIDTH'(RESET_DIV);

  logic [LW-1:0] r_lockCnt;
  logic          r_ready;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_lockCnt <= '0;
      r_ready   <= 1'b0;
    end else if (!r_ready) begin
      r_lockCnt <= r_lockCnt + LW'(1);
      if (r_lockCnt == LW'(LOCK_CYCLES - 1)) r_ready <= 1'b1;
    end
  end

  assign ready_o = r_ready;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_pend;
    logic             r_pendFlag;
    logic             r_stb;
    logic             r_tgl;
    logic             r_enQ;

    logic [WIDTH-1:0] w_wrDiv;
    logic [WIDTH-1:0] w_nextDiv;
    logic             w_we;
    logic             w_en;
    logic             w_restart;
    logic             w_term;
    logic             w_apply;

    assign w_wrDiv   = div_i[c*WIDTH +: WIDTH];
    assign w_we      = div_we_i[c];
    assign w_en      = chan_en_i[c];
    // A rising enable restarts the phase exactly like a sync on this channel.
    assign w_restart = !w_en || sync_i || !r_enQ;
    assign w_term    = (r_cnt == r_div);
    assign w_apply   = w_restart || w_term;
    assign w_nextDiv = w_we ? w_wrDiv : r_pend;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_cnt      <= '0;
        r_div      <= RDIV;
        r_pend     <= RDIV;
        r_pendFlag <= 1'b0;
        r_stb      <= 1'b0;
        r_tgl      <= 1'b0;
        r_enQ      <= 1'b0;
      end else begin
        r_enQ <= w_en;
        if (!r_ready) begin
          r_cnt <= '0;
          r_stb <= 1'b0;
          r_tgl <= 1'b0;
          if (w_we) begin
            r_pend     <= w_wrDiv;
            r_pendFlag <= 1'b1;
          end
        end else begin
          if (w_we) r_pend <= w_wrDiv;
          // New divisor only takes effect at a period boundary, so no runt strobes.
          if (w_apply) begin
            r_div      <= w_nextDiv;
            r_pendFlag <= 1'b0;
          end else if (w_we) begin
            r_pendFlag <= 1'b1;
          end

          if (w_restart) begin
            r_cnt <= '0;
            r_stb <= 1'b0;
            r_tgl <= 1'b0;
          end else if (w_term) begin
            r_cnt <= '0;
            r_stb <= 1'b1;
            r_tgl <= ~r_tgl;
          end else begin
            r_cnt <= r_cnt + WIDTH'(1);
            r_stb <= 1'b0;
          end
        end
      end
    end

    assign stb_o[c]  = r_stb;
    assign tgl_o[c]  = r_tgl;
    assign pend_o[c] = r_pendFlag;
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Scoreboard bench for clk_en_gen: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_clk_en_gen;

  localparam int CH   = 2;
  localparam int W    = 8;
  localparam int LOCK = 16;
  localparam int RDIV = 1;

  logic            clk;
  logic            rst_n;
  logic [CH*W-1:0] divIn;
  logic [CH-1:0]   divWe;
  logic [CH-1:0]   chanEn;
  logic            syncIn;
  logic [CH-1:0]   stb;
  logic [CH-1:0]   tgl;
  logic [CH-1:0]   pend;
  logic            ready;

  int cycle      = 0;
  int errCount   = 0;
  int checkCount = 0;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] mask;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sbq[$];
  exp_t monE;

  clk_en_gen #(
    .CHANNELS(CH), .WIDTH(W), .LOCK_CYCLES(LOCK), .RESET_DIV(RDIV)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .div_i(divIn), .div_we_i(divWe),
    .chan_en_i(chanEn), .sync_i(syncIn), .stb_o(stb), .tgl_o(tgl),
    .pend_o(pend), .ready_o(ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      0:       return 32'(stb);
      1:       return 32'(tgl);
      2:       return 32'(pend);
      default: return 32'(ready);
    endcase
  endfunction

  // Keeps the queue ordered by cycle so the monitor only ever looks at the head.
  task automatic expectAt(input int cyc, input int sel, input logic [31:0] mask,
                          input logic [31:0] val, input string name);
    exp_t e;
    int   pos;
    e.cyc = cyc; e.sel = sel; e.mask = mask; e.val = val; e.name = name;
    pos = sbq.size();
    for (int i = 0; i < sbq.size(); i++) begin
      if (sbq[i].cyc > cyc) begin
        pos = i;
        break;
      end
    end
    sbq.insert(pos, e);
  endtask

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cycle) begin
      monE = sbq.pop_front();
      if (monE.cyc < cycle) begin
        checkCount++;
        errCount++;
        $display("[TB] FAIL %s: check for cycle %0d skipped, now %0d", monE.name, monE.cyc, cycle);
      end else begin
        checkOutput(monE.name, sample(monE.sel) & monE.mask, monE.val);
      end
    end
  end

  task automatic applyStimulus(input logic [CH*W-1:0] d, input logic [CH-1:0] we,
                               input logic [CH-1:0] en, input logic s);
    divIn  = d;
    divWe  = we;
    chanEn = en;
    syncIn = s;
  endtask

  task automatic waitUntil(input int cyc);
    while (cycle < cyc) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0, r, s, e, g;
    rst_n = 1'b0;
    applyStimulus('0, '0, 2'b11, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset stb", 32'(stb), 0);
    checkOutput("reset tgl", 32'(tgl), 0);
    checkOutput("reset pend", 32'(pend), 0);
    checkOutput("reset ready", 32'(ready), 0);

    // Lock delay and default divisor 1
    c0 = cycle;
    rst_n = 1'b1;
    r = c0 + LOCK;
    expectAt(r - 1, 3, 1, 0, "lock ready low");
    expectAt(r,     3, 1, 1, "lock ready high");
    expectAt(r - 1, 0, 3, 0, "lock stb gated");
    expectAt(r,     0, 3, 0, "lock stb at R");
    expectAt(r + 1, 0, 3, 0, "lock stb R+1");
    expectAt(r + 2, 0, 3, 3, "lock first stb");
    expectAt(r + 3, 0, 3, 0, "lock stb R+3");
    expectAt(r + 4, 0, 3, 3, "lock second stb");
    expectAt(r + 2, 1, 3, 3, "lock tgl R+2");
    expectAt(r + 3, 1, 3, 3, "lock tgl R+3");
    expectAt(r + 4, 1, 3, 0, "lock tgl R+4");
    expectAt(r + 6, 1, 3, 3, "lock tgl R+6");
    expectAt(r,     2, 3, 0, "lock pend");
    waitUntil(r + 8);

    // Deferred update on ch0: div 3 then 7 written mid-period
    applyStimulus({8'd0, 8'd3}, 2'b01, 2'b11, 1'b0);
    waitUntil(cycle + 1);
    applyStimulus('0, 2'b00, 2'b11, 1'b1);
    s = cycle + 1;
    waitUntil(s);
    applyStimulus('0, 2'b00, 2'b11, 1'b0);
    expectAt(s,      0, 1, 0, "defer stb after sync");
    expectAt(s,      1, 1, 0, "defer tgl after sync");
    expectAt(s,      2, 1, 0, "defer pend applied by sync");
    expectAt(s + 4,  0, 1, 1, "defer stb div3 first");
    expectAt(s + 5,  0, 1, 0, "defer stb div3 gap");
    expectAt(s + 6,  2, 1, 1, "defer pend set");
    expectAt(s + 7,  2, 1, 1, "defer pend held");
    expectAt(s + 8,  0, 1, 1, "defer old period completes");
    expectAt(s + 8,  2, 1, 0, "defer pend cleared on apply");
    expectAt(s + 12, 0, 1, 0, "defer no old-div stb");
    expectAt(s + 15, 0, 1, 0, "defer stb before new period end");
    expectAt(s + 16, 0, 1, 1, "defer stb div7");
    expectAt(s + 17, 0, 1, 0, "defer stb div7 gap");
    expectAt(s + 24, 0, 1, 1, "defer stb div7 again");
    waitUntil(s + 5);
    applyStimulus({8'd0, 8'd7}, 2'b01, 2'b11, 1'b0);
    waitUntil(s + 6);
    applyStimulus('0, 2'b00, 2'b11, 1'b0);
    waitUntil(s + 25);

    // Sync alignment: ch0 div 2, ch1 div 4
    applyStimulus({8'd4, 8'd2}, 2'b11, 2'b11, 1'b0);
    waitUntil(cycle + 1);
    applyStimulus('0, 2'b00, 2'b11, 1'b1);
    s = cycle + 1;
    waitUntil(s);
    applyStimulus('0, 2'b00, 2'b11, 1'b0);
    expectAt(s,      0, 3, 0, "sync stb cleared");
    expectAt(s,      1, 3, 0, "sync tgl cleared");
    expectAt(s + 3,  0, 1, 1, "sync ch0 stb S+3");
    expectAt(s + 4,  0, 3, 0, "sync stb S+4");
    expectAt(s + 5,  0, 2, 2, "sync ch1 stb S+5");
    expectAt(s + 6,  0, 1, 1, "sync ch0 stb S+6");
    expectAt(s + 3,  1, 1, 1, "sync ch0 tgl S+3");
    expectAt(s + 5,  1, 2, 2, "sync ch1 tgl S+5");
    expectAt(s + 9,  0, 3, 0, "sync suppresses terminal stb");
    expectAt(s + 9,  1, 3, 0, "sync2 tgl cleared");
    expectAt(s + 10, 0, 2, 0, "sync ch1 rephased");
    expectAt(s + 12, 0, 1, 1, "sync2 ch0 stb");
    expectAt(s + 12, 1, 1, 1, "sync2 ch0 tgl");
    expectAt(s + 14, 0, 2, 2, "sync2 ch1 stb");
    waitUntil(s + 8);
    applyStimulus('0, 2'b00, 2'b11, 1'b1);
    waitUntil(s + 9);
    applyStimulus('0, 2'b00, 2'b11, 1'b0);
    waitUntil(s + 15);

    // Edge divisors: ch0 div 0, ch1 div 255
    applyStimulus({8'd255, 8'd0}, 2'b11, 2'b11, 1'b0);
    waitUntil(cycle + 1);
    applyStimulus('0, 2'b00, 2'b11, 1'b1);
    s = cycle + 1;
    waitUntil(s);
    applyStimulus('0, 2'b00, 2'b11, 1'b0);
    expectAt(s,       2, 3, 0, "edge pend applied");
    expectAt(s,       0, 1, 0, "edge div0 stb S");
    expectAt(s + 1,   0, 1, 1, "edge div0 stb S+1");
    expectAt(s + 2,   0, 1, 1, "edge div0 stb S+2");
    expectAt(s + 3,   0, 1, 1, "edge div0 stb S+3");
    expectAt(s + 1,   1, 1, 1, "edge div0 tgl S+1");
    expectAt(s + 2,   1, 1, 0, "edge div0 tgl S+2");
    expectAt(s + 3,   1, 1, 1, "edge div0 tgl S+3");
    expectAt(s + 300, 0, 1, 1, "edge div0 stb S+300");
    expectAt(s + 255, 0, 2, 0, "edge div255 before");
    expectAt(s + 256, 0, 2, 2, "edge div255 first");
    expectAt(s + 257, 0, 2, 0, "edge div255 after");
    expectAt(s + 511, 0, 2, 0, "edge div255 wrap before");
    expectAt(s + 512, 0, 2, 2, "edge div255 wrap");
    expectAt(s + 513, 0, 2, 0, "edge div255 wrap after");
    waitUntil(s + 514);

    // Disable/enable ch1 with a pending write while ch0 runs at div 2
    applyStimulus({8'd255, 8'd2}, 2'b11, 2'b11, 1'b0);
    waitUntil(cycle + 1);
    applyStimulus('0, 2'b00, 2'b11, 1'b1);
    s = cycle + 1;
    waitUntil(s);
    applyStimulus('0, 2'b00, 2'b11, 1'b0);
    e = s + 9;
    expectAt(s + 4,  2, 2, 2, "dis pend set");
    expectAt(s + 5,  2, 2, 2, "dis pend held");
    expectAt(s + 6,  2, 2, 0, "dis pend applied");
    expectAt(s + 6,  0, 2, 0, "dis stb off");
    expectAt(s + 6,  1, 2, 0, "dis tgl off");
    expectAt(e + 5,  0, 2, 0, "reen stb before");
    expectAt(e + 6,  0, 2, 2, "reen first stb");
    expectAt(e + 6,  1, 2, 2, "reen tgl");
    expectAt(s + 12, 0, 1, 1, "dis ch0 stb S+12");
    expectAt(s + 13, 0, 1, 0, "dis ch0 stb S+13");
    expectAt(s + 15, 0, 1, 1, "dis ch0 stb S+15");
    expectAt(s + 15, 1, 1, 1, "dis ch0 tgl S+15");
    waitUntil(s + 3);
    applyStimulus({8'd5, 8'd0}, 2'b10, 2'b11, 1'b0);
    waitUntil(s + 4);
    applyStimulus('0, 2'b00, 2'b11, 1'b0);
    waitUntil(s + 5);
    applyStimulus('0, 2'b00, 2'b01, 1'b0);
    waitUntil(s + 8);
    applyStimulus('0, 2'b00, 2'b11, 1'b0);
    waitUntil(s + 16);

    // Asynchronous reset mid-period
    checkOutput("prereset tgl", 32'(tgl), 3);
    checkOutput("prereset ready", 32'(ready), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset stb", 32'(stb), 0);
    checkOutput("async reset tgl", 32'(tgl), 0);
    checkOutput("async reset pend", 32'(pend), 0);
    checkOutput("async reset ready", 32'(ready), 0);
    g = s + 18;
    waitUntil(g);
    rst_n = 1'b1;
    expectAt(g + 1,  2, 3, 0, "relock pend");
    expectAt(g + 15, 3, 1, 0, "relock ready low");
    expectAt(g + 15, 0, 3, 0, "relock stb gated");
    expectAt(g + 16, 3, 1, 1, "relock ready high");
    expectAt(g + 17, 0, 3, 0, "relock stb R+1");
    expectAt(g + 18, 0, 3, 3, "relock default div stb");
    expectAt(g + 18, 1, 3, 3, "relock tgl");
    expectAt(g + 19, 0, 3, 0, "relock stb R+3");
    expectAt(g + 20, 0, 3, 3, "relock stb R+4");
    waitUntil(g + 22);

    while (sbq.size() > 0) begin
      monE = sbq.pop_front();
      checkCount++;
      errCount++;
      $display("[TB] FAIL %s: never checked (cycle %0d)", monE.name, monE.cyc);
    end
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
